// File: rtl/axis_bram_reader_pkg.sv
// Shared definitions for the AXI4-Stream BRAM reader.
//   state_t          : playback FSM encoding (IDLE / PRIME / STREAM)
//   BRAM_RD_LATENCY  : read latency of the BRAM port, in clock cycles
package axis_bram_reader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2
    } state_t;

    // The BRAM read port is fixed at one cycle of latency. The single PRIME
    // cycle and the look-ahead address mux in the reader both depend on it.
    localparam int BRAM_RD_LATENCY = 1;

endpackage

// File: rtl/axis_bram_reader_if.sv
// AXI4-Stream channel used by the BRAM reader.
//   tdata  : stream word
//   tvalid : word valid
//   tready : consumer ready
//   tlast  : last word of a pass
// master modport drives data/valid/last; slave modport drives ready.
interface axis_bram_reader_if #(
    parameter int AXIS_TDATA_WIDTH = 32
);
    logic [AXIS_TDATA_WIDTH-1:0] tdata;
    logic                        tvalid;
    logic                        tready;
    logic                        tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_bram_reader.sv
// Streams BRAM contents (addresses 0..cfg_data) out as AXI4-Stream, either
// once or in continuous wrap-around, at one word per cycle with no bubbles.
// Ports:
//   aclk, areset        : clock, asynchronous active-high reset
//   cfg_data, cfg_cont  : last address and continuous-mode flag, taken on start
//   start, stop         : one-cycle control pulses
//   busy, sts_data      : playback active, address of the word on tdata
//   m_axis              : AXI4-Stream master
//   bram_porta_*        : BRAM read port (1-cycle read latency)
module axis_bram_reader
    import axis_bram_reader_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int BRAM_ADDR_WIDTH  = 10
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [BRAM_ADDR_WIDTH-1:0]  cfg_data,
    input  logic                        cfg_cont,
    input  logic                        start,
    input  logic                        stop,
    output logic                        busy,
    output logic [BRAM_ADDR_WIDTH-1:0]  sts_data,
    axis_bram_reader_if.master          m_axis,
    output logic                        bram_porta_clk,
    output logic                        bram_porta_rst,
    output logic [BRAM_ADDR_WIDTH-1:0]  bram_porta_addr,
    input  logic [AXIS_TDATA_WIDTH-1:0] bram_porta_rddata
);

    state_t                     state, state_nxt;
    logic [BRAM_ADDR_WIDTH-1:0] addr_reg, last_reg, addr_next;
    logic                       cont_reg, stop_pend;
    logic                       tvalid_w, tlast_w, beat, at_last;

    assign at_last   = (addr_reg == last_reg);
    assign addr_next = at_last ? '0 : addr_reg + BRAM_ADDR_WIDTH'(1);
    assign beat      = tvalid_w & m_axis.tready;

    // Present the next address as soon as the current word is accepted, so the
    // data arriving one cycle later already belongs to the new addr_reg. While
    // stalled the same address is re-read and tdata stays stable.
    assign bram_porta_addr = beat ? addr_next : addr_reg;
    assign bram_porta_clk  = aclk;
    assign bram_porta_rst  = areset;

    assign m_axis.tdata  = bram_porta_rddata;
    assign m_axis.tvalid = tvalid_w;
    assign m_axis.tlast  = tlast_w;
    assign busy          = (state != IDLE);
    assign sts_data      = addr_reg;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tvalid_w  = 1'b0;
        tlast_w   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = PRIME;
                end
            end
            // Address 0 is on the bus for one cycle to cover the read latency.
            PRIME: begin
                state_nxt = STREAM;
            end
            STREAM: begin
                tvalid_w = 1'b1;
                tlast_w  = at_last;
                // A stop arriving together with the tlast beat ends playback there.
                if (beat && at_last && (!cont_reg || stop_pend || stop)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            addr_reg  <= '0;
            last_reg  <= '0;
            cont_reg  <= 1'b0;
            stop_pend <= 1'b0;
        end else if (state == IDLE) begin
            addr_reg <= '0;
            if (start) begin
                last_reg  <= cfg_data;
                cont_reg  <= cfg_cont;
                stop_pend <= 1'b0;
            end
        end else begin
            if (stop) begin
                stop_pend <= 1'b1;
            end
            if (beat) begin
                addr_reg <= addr_next;
            end
        end
    end

endmodule

// File: tb/tb_axis_bram_reader.sv
module tb_axis_bram_reader;
    import axis_bram_reader_pkg::*;

    localparam int DW = 32;
    localparam int AW = 10;

    logic          aclk;
    logic          areset;
    logic [AW-1:0] cfg_data;
    logic          cfg_cont;
    logic          start;
    logic          stop;
    logic          busy;
    logic [AW-1:0] sts_data;
    logic          bram_clk;
    logic          bram_rst;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_rddata;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int checks   = 0;
    int failures = 0;

    axis_bram_reader_if #(.AXIS_TDATA_WIDTH(DW)) axis ();

    axis_bram_reader #(
        .AXIS_TDATA_WIDTH(DW),
        .BRAM_ADDR_WIDTH (AW)
    ) dut (
        .aclk             (aclk),
        .areset           (areset),
        .cfg_data         (cfg_data),
        .cfg_cont         (cfg_cont),
        .start            (start),
        .stop             (stop),
        .busy             (busy),
        .sts_data         (sts_data),
        .m_axis           (axis),
        .bram_porta_clk   (bram_clk),
        .bram_porta_rst   (bram_rst),
        .bram_porta_addr  (bram_addr),
        .bram_porta_rddata(bram_rddata)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // BRAM model: one cycle read latency, contents mem[i] = i + 100
    always @(posedge bram_clk) bram_rddata <= mem[bram_addr];

    typedef struct {
        logic [AW-1:0] last;
        logic          cont;
        logic [15:0]   rpat;      // tready pattern, bit (cycle % 16)
        int            stop_at;   // pulse stop when this many beats seen (-1 none)
        int            poke_at;   // pulse start (with other cfg) at this beat (-1 none)
        int            exp_beats; // beats expected before returning to idle
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic run_case(input int idx, input vec_t v);
        int            beats;
        int            cyc;
        int            budget;
        logic [AW-1:0] ea;
        bit            stop_done;
        bit            poke_done;
        beats     = 0;
        cyc       = 0;
        ea        = '0;
        stop_done = 1'b0;
        poke_done = 1'b0;
        budget    = v.exp_beats * 4 + 40;
        @(negedge aclk);
        cfg_data    = v.last;
        cfg_cont    = v.cont;
        start       = 1'b1;
        axis.tready = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        chk($sformatf("v%0d prime_tvalid", idx), 32'(axis.tvalid), 32'd0);
        chk($sformatf("v%0d prime_busy", idx), 32'(busy), 32'd1);
        while (beats < v.exp_beats && cyc < budget) begin
            @(negedge aclk);
            stop     = 1'b0;
            start    = 1'b0;
            cfg_data = v.last;
            cfg_cont = v.cont;
            if (v.stop_at == beats && !stop_done) begin
                stop      = 1'b1;
                stop_done = 1'b1;
            end
            if (v.poke_at == beats && !poke_done) begin
                start     = 1'b1;
                cfg_data  = AW'(1);
                cfg_cont  = ~v.cont;
                poke_done = 1'b1;
            end
            axis.tready = v.rpat[cyc % 16];
            chk($sformatf("v%0d tvalid c%0d", idx, cyc), 32'(axis.tvalid), 32'd1);
            if (axis.tvalid) begin
                chk($sformatf("v%0d tdata a%0d", idx, ea), axis.tdata, 32'(ea) + 32'd100);
                chk($sformatf("v%0d sts a%0d", idx, ea), 32'(sts_data), 32'(ea));
                chk($sformatf("v%0d tlast a%0d", idx, ea), 32'(axis.tlast), 32'(ea == v.last));
                chk($sformatf("v%0d busy a%0d", idx, ea), 32'(busy), 32'd1);
                if (axis.tready) begin
                    beats++;
                    ea = (ea == v.last) ? '0 : ea + AW'(1);
                end
            end
            cyc++;
        end
        chk($sformatf("v%0d beat_count", idx), 32'(beats), 32'(v.exp_beats));
        @(negedge aclk);
        stop        = 1'b0;
        start       = 1'b0;
        axis.tready = 1'b1;
        chk($sformatf("v%0d end_tvalid", idx), 32'(axis.tvalid), 32'd0);
        chk($sformatf("v%0d end_busy", idx), 32'(busy), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'(i) + 32'd100;

        vecs[0] = '{last: 10'd3,    cont: 1'b0, rpat: 16'hFFFF, stop_at: -1,   poke_at: -1, exp_beats: 4};
        vecs[1] = '{last: 10'd2,    cont: 1'b1, rpat: 16'hFFFF, stop_at: 4,    poke_at: -1, exp_beats: 6};
        vecs[2] = '{last: 10'd4,    cont: 1'b0, rpat: 16'h9999, stop_at: -1,   poke_at: -1, exp_beats: 5};
        vecs[3] = '{last: 10'd0,    cont: 1'b0, rpat: 16'hFFFF, stop_at: -1,   poke_at: -1, exp_beats: 1};
        vecs[4] = '{last: 10'd1,    cont: 1'b1, rpat: 16'hFFFF, stop_at: 1,    poke_at: -1, exp_beats: 2};
        vecs[5] = '{last: 10'd0,    cont: 1'b1, rpat: 16'hFFFF, stop_at: 2,    poke_at: -1, exp_beats: 3};
        vecs[6] = '{last: 10'd1023, cont: 1'b1, rpat: 16'hFFFF, stop_at: 1030, poke_at: -1, exp_beats: 2048};
        vecs[7] = '{last: 10'd3,    cont: 1'b0, rpat: 16'hFFFF, stop_at: 1,    poke_at: -1, exp_beats: 4};
        vecs[8] = '{last: 10'd5,    cont: 1'b0, rpat: 16'hFFFF, stop_at: -1,   poke_at: 2,  exp_beats: 6};

        areset      = 1'b1;
        cfg_data    = '0;
        cfg_cont    = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        axis.tready = 1'b0;
        repeat (2) @(negedge aclk);
        chk("rst tvalid", 32'(axis.tvalid), 32'd0);
        chk("rst tlast", 32'(axis.tlast), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst sts", 32'(sts_data), 32'd0);
        chk("rst addr", 32'(bram_addr), 32'd0);
        chk("rst bram_rst", 32'(bram_rst), 32'd1);
        areset = 1'b0;
        @(negedge aclk);
        chk("idle tvalid", 32'(axis.tvalid), 32'd0);
        chk("idle bram_rst", 32'(bram_rst), 32'd0);

        for (int i = 0; i < 9; i++) run_case(i, vecs[i]);

        // Reset in the middle of a continuous playback
        @(negedge aclk);
        cfg_data    = 10'd7;
        cfg_cont    = 1'b1;
        start       = 1'b1;
        axis.tready = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        repeat (3) @(negedge aclk);
        chk("mid tvalid_before", 32'(axis.tvalid), 32'd1);
        @(posedge aclk);
        #2 areset = 1'b1;
        #1;
        chk("mid rst tvalid", 32'(axis.tvalid), 32'd0);
        chk("mid rst tlast", 32'(axis.tlast), 32'd0);
        chk("mid rst busy", 32'(busy), 32'd0);
        chk("mid rst sts", 32'(sts_data), 32'd0);
        chk("mid rst addr", 32'(bram_addr), 32'd0);
        @(negedge aclk);
        areset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            chk($sformatf("post rst tvalid %0d", i), 32'(axis.tvalid), 32'd0);
        end

        // New start after reset replays from address 0
        run_case(9, vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
